sd_clk_edge_gen: RTL and testbench



---
 rtl/sd_clk_pkg.sv | 14 +
 rtl/sd_clk_half_cnt.sv | 34 +++
 rtl/sd_clk_edge_gen.sv | 118 +++++++++++
 tb/tb_sd_clk_edge_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sd_clk_pkg.sv
// sd_clk_pkg: shared types and defaults for the SD bus clock edge generator.
// Holds the generator state encoding and the default divider width.
// Imported by sd_clk_edge_gen and sd_clk_half_cnt.
package sd_clk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_LOW  = 2'd1,
        RUN_HIGH = 2'd2
    } sd_clk_state_e;

    localparam int SD_DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/sd_clk_half_cnt.sv
// sd_clk_half_cnt: half-period counter for the SD clock generator.
// Latency: count updates one clk after clear/enable; tc is combinational from count.
// Backpressure: none; clear has priority over enable, no saturation needed (wraps never reached).
// Ports: clk, rst (async high), clear, enable, limit -> tc (count == limit).
module sd_clk_half_cnt
    import sd_clk_pkg::*;
#(
    parameter int WIDTH = SD_DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    // The owner clears on terminal count, so count never exceeds limit
    // and the all-ones limit does not overflow.
    assign tc = (count == limit);

endmodule

// File: rtl/sd_clk_edge_gen.sv
// sd_clk_edge_gen: divided SD bus clock with registered rise/fall strobes.
// Latency: first rise divider+1 clks after enable is sampled in IDLE; half-period = divider+1.
// Backpressure: none; enable low stops at once in the low phase, after a full high phase otherwise.
// Ports: clk, rst (async high), enable, divider -> sd_clk, rise, fall, active.
// Build option SD_CLK_EDGE_GEN_DIV_ACK_EN adds div_ack, a 1-cycle pulse when a divider is loaded.
module sd_clk_edge_gen
    import sd_clk_pkg::*;
#(
    parameter int DIV_WIDTH = SD_DIV_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] divider,
`ifdef SD_CLK_EDGE_GEN_DIV_ACK_EN
    output logic                 div_ack,
`endif
    output logic                 sd_clk,
    output logic                 rise,
    output logic                 fall,
    output logic                 active
);

    sd_clk_state_e        state;
    logic [DIV_WIDTH-1:0] div_cur;
    logic                 tc;
    logic                 cnt_clr;
    logic                 cnt_inc;

    // Counter runs in both run states; it is cleared while idle, at every
    // half-period boundary, and when a low phase is abandoned.
    always_comb begin
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = (state != IDLE);
        cnt_clr = (state == IDLE) || tc || ((state == RUN_LOW) && !enable);
    end

    sd_clk_half_cnt #(
        .WIDTH (DIV_WIDTH)
    ) u_half_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clr),
        .enable (cnt_inc),
        .limit  (div_cur),
        .tc     (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            div_cur <= '0;
            sd_clk  <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            active  <= 1'b0;
`ifdef SD_CLK_EDGE_GEN_DIV_ACK_EN
            div_ack <= 1'b0;
`endif
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
`ifdef SD_CLK_EDGE_GEN_DIV_ACK_EN
            div_ack <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    sd_clk <= 1'b0;
                    if (enable) begin
                        div_cur <= divider;
                        state   <= RUN_LOW;
                        active  <= 1'b1;
`ifdef SD_CLK_EDGE_GEN_DIV_ACK_EN
                        div_ack <= 1'b1;
`endif
                    end
                end
                RUN_LOW: begin
                    // Stopping in the low phase is always safe: sd_clk is
                    // already 0, so no runt pulse and no strobe.
                    if (!enable) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end else if (tc) begin
                        sd_clk <= 1'b1;
                        rise   <= 1'b1;
                        state  <= RUN_HIGH;
                    end
                end
                RUN_HIGH: begin
                    // The high phase always completes; enable is only looked
                    // at on the falling edge.
                    if (tc) begin
                        sd_clk <= 1'b0;
                        fall   <= 1'b1;
                        if (enable) begin
                            div_cur <= divider;
                            state   <= RUN_LOW;
`ifdef SD_CLK_EDGE_GEN_DIV_ACK_EN
                            div_ack <= 1'b1;
`endif
                        end else begin
                            state  <= IDLE;
                            active <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    sd_clk <= 1'b0;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_clk_edge_gen.sv
// tb_sd_clk_edge_gen: directed bench for sd_clk_edge_gen.
// Observed vector is {sd_clk, rise, fall, active}, sampled 1 ns after each rising clk edge.
module tb_sd_clk_edge_gen;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] divider;
    logic       sd_clk;
    logic       rise;
    logic       fall;
    logic       active;
`ifdef SD_CLK_EDGE_GEN_DIV_ACK_EN
    logic       div_ack;
`endif

    int checks = 0;
    int errors = 0;

    sd_clk_edge_gen #(
        .DIV_WIDTH (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .divider (divider),
`ifdef SD_CLK_EDGE_GEN_DIV_ACK_EN
        .div_ack (div_ack),
`endif
        .sd_clk  (sd_clk),
        .rise    (rise),
        .fall    (fall),
        .active  (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check the output vector and, when present, the divider-load pulse.
    task automatic chk_out(input string tag, input logic [3:0] exp, input logic ack);
        chk(tag, {sd_clk, rise, fall, active}, exp);
`ifdef SD_CLK_EDGE_GEN_DIV_ACK_EN
        chk({tag, "_ack"}, {3'b000, div_ack}, {3'b000, ack});
`endif
    endtask

    // Advance one clk and check.
    task automatic cyc(input string tag, input logic [3:0] exp, input logic ack);
        @(posedge clk);
        #1;
        chk_out(tag, exp, ack);
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b1;
        divider = 8'd3;

        // Reset held three cycles with enable asserted: everything stays low.
        for (int i = 0; i < 3; i++) cyc("reset_hold", 4'b0000, 1'b0);
        rst = 1'b0;

        // divider=3: rise 4 cycles after enable sampled, then period 8, 50% duty.
        cyc("d3_start", 4'b0001, 1'b1);
        for (int i = 1; i < 4; i++) cyc("d3_first_low", 4'b0001, 1'b0);
        for (int k = 0; k < 16; k++) begin
            logic [3:0] e;
            if (k % 8 == 0)      e = 4'b1101;
            else if (k % 8 < 4)  e = 4'b1001;
            else if (k % 8 == 4) e = 4'b0011;
            else                 e = 4'b0001;
            cyc("d3_period", e, (k % 8 == 4));
        end

        // Drop enable on the last low cycle before a rise: no rise, IDLE.
        enable = 1'b0;
        cyc("drop_low_no_rise", 4'b0000, 1'b0);

        // divider=0: sd_clk toggles every cycle, strobes alternate.
        divider = 8'd0;
        enable  = 1'b1;
        cyc("d0_start", 4'b0001, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            if (i % 2 == 1) cyc("d0_rise", 4'b1101, 1'b0);
            else            cyc("d0_fall", 4'b0011, 1'b1);
        end
        enable = 1'b0;
        cyc("d0_stop", 4'b0000, 1'b0);

        // divider=2, change to 5 while high at counter=1.
        divider = 8'd2;
        enable  = 1'b1;
        cyc("d2_start", 4'b0001, 1'b1);
        cyc("d2_low1", 4'b0001, 1'b0);
        cyc("d2_low2", 4'b0001, 1'b0);
        cyc("d2_rise", 4'b1101, 1'b0);
        cyc("d2_high_c1", 4'b1001, 1'b0);
        divider = 8'd5;
        cyc("d2_high_c2", 4'b1001, 1'b0);
        cyc("d2_fall_reload", 4'b0011, 1'b1);
        for (int i = 0; i < 5; i++) cyc("d5_low", 4'b0001, 1'b0);
        cyc("d5_rise", 4'b1101, 1'b0);

        // Divider=4 lands at the next fall; then drop enable 1 cycle into high.
        divider = 8'd4;
        for (int i = 0; i < 5; i++) cyc("d5_high", 4'b1001, 1'b0);
        cyc("d5_fall_reload4", 4'b0011, 1'b1);
        for (int i = 0; i < 4; i++) cyc("d4_low", 4'b0001, 1'b0);
        cyc("d4_rise", 4'b1101, 1'b0);
        cyc("d4_high1", 4'b1001, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) cyc("d4_high_kept", 4'b1001, 1'b0);
        cyc("d4_fall_to_idle", 4'b0010, 1'b0);
        cyc("d4_idle1", 4'b0000, 1'b0);
        cyc("d4_idle2", 4'b0000, 1'b0);

        // Re-enable with divider=1, then drop enable in the low phase.
        divider = 8'd1;
        enable  = 1'b1;
        cyc("d1_start", 4'b0001, 1'b1);
        cyc("d1_low", 4'b0001, 1'b0);
        cyc("d1_rise", 4'b1101, 1'b0);
        cyc("d1_high", 4'b1001, 1'b0);
        cyc("d1_fall", 4'b0011, 1'b1);
        enable = 1'b0;
        cyc("d1_drop_low", 4'b0000, 1'b0);
        cyc("d1_idle", 4'b0000, 1'b0);

        // divider=7: async reset in the middle of a high phase.
        divider = 8'd7;
        enable  = 1'b1;
        cyc("d7_start", 4'b0001, 1'b1);
        for (int i = 0; i < 7; i++) cyc("d7_low", 4'b0001, 1'b0);
        cyc("d7_rise", 4'b1101, 1'b0);
        cyc("d7_high1", 4'b1001, 1'b0);
        cyc("d7_high2", 4'b1001, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst_immediate", 4'b0000, 1'b0);
        cyc("async_rst_held", 4'b0000, 1'b0);
        rst    = 1'b0;
        enable = 1'b0;
        cyc("post_rst_idle", 4'b0000, 1'b0);
        enable = 1'b1;
        cyc("post_rst_start", 4'b0001, 1'b1);
        for (int i = 0; i < 7; i++) cyc("post_rst_low", 4'b0001, 1'b0);
        cyc("post_rst_rise", 4'b1101, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
